// File: rtl/crc_job_sched.sv
// rtl/crc_job_sched.sv - round-robin scheduler sharing one CRC-5 engine between requesters
module crc_job_sched #(
  parameter int NREQ    = 4,
  parameter int DW      = 10,
  parameter int CW      = 5,
  parameter int TMO     = 63,
  parameter int GAP_CYC = 2,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               eng_en,
  output logic [DW-1:0]      eng_data,
  input  logic               eng_done,
  input  logic [CW-1:0]      eng_crc,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW+CW-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  // Pointer starts at the last index so the first search begins at requester 0.
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);
  // Counters run from 0, so the terminal values are one below the cycle counts.
  localparam logic [7:0]     TMO_LAST = 8'(TMO - 1);
  localparam logic [7:0]     GAP_LAST = 8'(GAP_CYC - 1);

  state_t             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [DW-1:0]      eng_data_q, eng_data_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [DW+CW-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [7:0]         tmo_cnt_q, tmo_cnt_d;
  logic [7:0]         gap_cnt_q, gap_cnt_d;

  logic               hi_vld, lo_vld;
  logic [IDW-1:0]     hi_idx, lo_idx;
  logic [NREQ-1:0]    hi_oh, lo_oh;
  logic [DW-1:0]      hi_data, lo_data;
  logic               pick_vld;
  logic [IDW-1:0]     pick_idx;
  logic [NREQ-1:0]    pick_oh;
  logic [DW-1:0]      pick_data;

  // Round-robin search: first set bit above the last grant, else first set bit at or below it.
  always_comb begin
    hi_vld  = 1'b0;
    hi_idx  = '0;
    hi_oh   = '0;
    hi_data = '0;
    lo_vld  = 1'b0;
    lo_idx  = '0;
    lo_oh   = '0;
    lo_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (req[k] && (k > int'(last_q)) && !hi_vld) begin
        hi_vld   = 1'b1;
        hi_idx   = IDW'(k);
        hi_oh[k] = 1'b1;
        hi_data  = req_data[k*DW +: DW];
      end
      if (req[k] && (k <= int'(last_q)) && !lo_vld) begin
        lo_vld   = 1'b1;
        lo_idx   = IDW'(k);
        lo_oh[k] = 1'b1;
        lo_data  = req_data[k*DW +: DW];
      end
    end
    pick_vld  = hi_vld | lo_vld;
    pick_idx  = hi_vld ? hi_idx  : lo_idx;
    pick_oh   = hi_vld ? hi_oh   : lo_oh;
    pick_data = hi_vld ? hi_data : lo_data;
  end

  // Next-state and datapath updates for grant, launch, wait, respond and gap phases.
  always_comb begin
    state_d    = state_q;
    gnt_d      = '0;
    eng_data_d = eng_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    last_d     = last_q;
    tmo_cnt_d  = tmo_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d      = pick_oh;
          eng_data_d = pick_data;
          rsp_id_d   = pick_idx;
          last_d     = pick_idx;
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tmo_cnt_d = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // A completion arriving on the timeout cycle still counts as success.
        if (eng_done) begin
          rsp_data_d = {eng_data_q, eng_crc};
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          rsp_data_d = {eng_data_q, {CW{1'b0}}};
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        // Keeps eng_en low long enough for the engine's edge detector to rearm.
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      eng_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      last_q     <= LAST_RST;
      tmo_cnt_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      eng_data_q <= eng_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      last_q     <= last_d;
      tmo_cnt_q  <= tmo_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign eng_en    = (state_q == S_LAUNCH) || (state_q == S_WAIT);
  assign eng_data  = eng_data_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule
